// File: rtl/key_zone_detect.sv
// key_zone_detect: per-frame dark-pixel census across horizontal piano-key
// zones inside a detection band, thresholded and debounced into a key bitmap.
// Optional build macro KEY_ZONE_MIRROR_EN reverses the zone-to-key mapping
// for a mirror-image camera view (leftmost pixels drive keys[KEYS-1]).
`timescale 1ns/1ps
module key_zone_detect #(
  parameter int KEYS       = 8,
  parameter int KEY_W      = 80,
  parameter int BAND_TOP   = 400,
  parameter int BAND_BOT   = 440,
  parameter int THRESH     = 64,
  parameter int HIT_MIN    = 200,
  parameter int DEB_FRAMES = 2
) (
  input  logic            clk,
  input  logic            rst,        // asynchronous, active-low
  input  logic            sof,
  input  logic            eol,
  input  logic            eof,
  input  logic            pix_valid,
  input  logic [15:0]     pix_data,
  output logic [KEYS-1:0] keys,
  output logic [KEYS-1:0] key_onset,
  output logic            keys_valid,
  output logic            busy,
  output logic [15:0]     debug_out
);

  localparam int ZW = (KEYS  > 1) ? $clog2(KEYS)  : 1;
  localparam int OW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int YW = 12;

  localparam logic [ZW-1:0] ZONE_LAST = ZW'(KEYS - 1);
  localparam logic [OW-1:0] OFF_LAST  = OW'(KEY_W - 1);
  localparam logic [YW-1:0] Y_TOP     = YW'(BAND_TOP);
  localparam logic [YW-1:0] Y_BOT     = YW'(BAND_BOT);
  localparam logic [YW-1:0] Y_MAX     = {YW{1'b1}};
  localparam logic [8:0]    DARK_LIM  = 9'(THRESH);
  localparam logic [15:0]   HIT_LIM   = 16'(HIT_MIN);
  localparam logic [3:0]    DEB_LIM   = 4'(DEB_FRAMES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_EVAL  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  function automatic logic [7:0] luma(input logic [15:0] p);
    return {2'b00, p[15:11], 1'b0} + {2'b00, p[10:5]} + {2'b00, p[4:0], 1'b0};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat8(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

  logic [1:0]      r_state;
  logic [ZW-1:0]   r_zone;
  logic [OW-1:0]   r_off;
  logic            r_inr;
  logic [YW-1:0]   r_y;
  logic [15:0]     r_cnt [KEYS];
  logic [3:0]      r_agree [KEYS];
  logic [ZW-1:0]   r_eidx;
  logic            r_sof_lat;
  logic [KEYS-1:0] r_keys;
  logic [KEYS-1:0] r_onset;
  logic [KEYS-1:0] r_stage;
  logic [KEYS-1:0] r_hit;
  logic            r_kv;

  logic            w_start;
  logic            w_take;
  logic            w_eol_acc;
  logic [ZW-1:0]   w_zone_b;
  logic [OW-1:0]   w_off_b;
  logic            w_inr_b;
  logic [YW-1:0]   w_y_b;
  logic [ZW-1:0]   w_zone_n;
  logic [OW-1:0]   w_off_n;
  logic            w_inr_n;
  logic [YW-1:0]   w_y_n;
  logic            w_band;
  logic            w_dark;
  logic            w_inc;
  logic [ZW-1:0]   w_zidx;
  logic            w_hit;
  logic            w_key_old;
  logic            w_new_bit;
  logic [3:0]      w_agree_inc;
  logic [3:0]      w_agree_nxt;
  logic [KEYS-1:0] w_stage_full;
  logic [7:0]      w_hit8;

  // Frame-start detection and the running x/y position for the current pixel
  always_comb begin
    w_start   = (sof && (r_state == S_IDLE || r_state == S_ACCUM)) ||
                (r_state == S_OUT && (r_sof_lat || sof));
    w_take    = pix_valid && (r_state == S_ACCUM || (r_state == S_IDLE && sof));
    w_eol_acc = eol && (r_state == S_ACCUM) && !w_start;
    // A pixel arriving with sof sits at x=0, y=0 of the new frame
    w_zone_b  = w_start ? '0   : r_zone;
    w_off_b   = w_start ? '0   : r_off;
    w_inr_b   = w_start ? 1'b1 : r_inr;
    w_y_b     = w_start ? '0   : r_y;
    w_zone_n  = w_zone_b;
    w_off_n   = w_off_b;
    w_inr_n   = w_inr_b;
    if (w_take && w_inr_b) begin
      if (w_off_b == OFF_LAST) begin
        w_off_n = '0;
        if (w_zone_b == ZONE_LAST) w_inr_n = 1'b0;
        else                       w_zone_n = w_zone_b + 1'b1;
      end else begin
        w_off_n = w_off_b + 1'b1;
      end
    end
    if (w_eol_acc) begin
      w_zone_n = '0;
      w_off_n  = '0;
      w_inr_n  = 1'b1;
    end
    w_y_n  = (w_eol_acc && r_y != Y_MAX) ? r_y + 1'b1 : w_y_b;
    w_band = (w_y_b >= Y_TOP) && (w_y_b < Y_BOT);
    w_dark = {1'b0, luma(pix_data)} < DARK_LIM;
    w_inc  = w_take && w_inr_b && w_band && w_dark;
`ifdef KEY_ZONE_MIRROR_EN
    w_zidx = ZONE_LAST - w_zone_b;
`else
    w_zidx = w_zone_b;
`endif
  end

  // Position counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_zone <= '0;
      r_off  <= '0;
      r_inr  <= 1'b0;
      r_y    <= '0;
    end else begin
      r_zone <= w_zone_n;
      r_off  <= w_off_n;
      r_inr  <= w_inr_n;
      r_y    <= w_y_n;
    end
  end

  // Per-zone dark-pixel counters, cleared at each frame start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KEYS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < KEYS; i++) begin
        if (w_start)
          r_cnt[i] <= (w_inc && w_zidx == ZW'(i)) ? 16'd1 : 16'd0;
        else if (w_inc && w_zidx == ZW'(i))
          r_cnt[i] <= sat_inc16(r_cnt[i]);
      end
    end
  end

  // Debounce decision for the zone currently under evaluation
  always_comb begin
    w_hit       = r_cnt[r_eidx] >= HIT_LIM;
    w_key_old   = r_keys[r_eidx];
    w_agree_inc = r_agree[r_eidx] + 4'd1;
    w_new_bit   = w_key_old;
    w_agree_nxt = 4'd0;
    if (w_hit != w_key_old) begin
      if (w_agree_inc == DEB_LIM) w_new_bit   = ~w_key_old;
      else                        w_agree_nxt = w_agree_inc;
    end
    w_stage_full          = r_stage;
    w_stage_full[r_eidx]  = w_new_bit;
  end

  // Frame FSM, debounce state and published outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_eidx    <= '0;
      r_sof_lat <= 1'b0;
      r_keys    <= '0;
      r_onset   <= '0;
      r_stage   <= '0;
      r_hit     <= '0;
      r_kv      <= 1'b0;
      for (int i = 0; i < KEYS; i++) r_agree[i] <= '0;
    end else begin
      r_kv    <= 1'b0;
      r_onset <= '0;
      case (r_state)
        S_IDLE: begin
          if (sof) r_state <= S_ACCUM;
        end
        S_ACCUM: begin
          // A bare sof restarts accumulation through w_start; only eof evaluates
          if (!sof && eof) begin
            r_state <= S_EVAL;
            r_eidx  <= '0;
          end
        end
        S_EVAL: begin
          if (sof) r_sof_lat <= 1'b1;
          r_stage[r_eidx] <= w_new_bit;
          r_agree[r_eidx] <= w_agree_nxt;
          r_hit[r_eidx]   <= w_hit;
          if (r_eidx == ZONE_LAST) begin
            r_state <= S_OUT;
            r_keys  <= w_stage_full;
            r_onset <= w_stage_full & ~r_keys;
            r_kv    <= 1'b1;
          end else begin
            r_eidx <= r_eidx + 1'b1;
          end
        end
        default: begin
          r_sof_lat <= 1'b0;
          r_state   <= (r_sof_lat || sof) ? S_ACCUM : S_IDLE;
        end
      endcase
    end
  end

  // Low eight hit bits for the debug word
  always_comb begin
    w_hit8 = '0;
    for (int i = 0; i < 8 && i < KEYS; i++) w_hit8[i] = r_hit[i];
  end

  assign keys       = r_keys;
  assign key_onset  = r_onset;
  assign keys_valid = r_kv;
  assign busy       = (r_state == S_EVAL);
  assign debug_out  = {w_hit8, sat8(r_cnt[0])};

endmodule

// File: tb/tb_key_zone_detect.sv
// Directed bench for key_zone_detect: reduced-length frames that still place
// every pixel at its true (x, y), with hand-computed expected bitmaps.
`timescale 1ns/1ps
module tb_key_zone_detect;
  localparam int KEYS = 8;

`ifdef KEY_ZONE_MIRROR_EN
  localparam logic [7:0]  MIR_KEY = 8'h80;
  localparam logic [15:0] MIR_DBG = 16'h8000;
`else
  localparam logic [7:0]  MIR_KEY = 8'h01;
  localparam logic [15:0] MIR_DBG = 16'h01FF;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sof = 1'b0;
  logic        eol = 1'b0;
  logic        eof = 1'b0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = 16'h0000;
  logic [7:0]  keys;
  logic [7:0]  key_onset;
  logic        keys_valid;
  logic        busy;
  logic [15:0] debug_out;

  int n_vec = 0;
  int n_err = 0;
  int kv_cnt = 0;
  int kv0;

  key_zone_detect #(
    .KEYS(8), .KEY_W(80), .BAND_TOP(400), .BAND_BOT(440),
    .THRESH(64), .HIT_MIN(200), .DEB_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .sof(sof), .eol(eol), .eof(eof),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .keys(keys), .key_onset(key_onset), .keys_valid(keys_valid),
    .busy(busy), .debug_out(debug_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (keys_valid) kv_cnt <= kv_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic blank_rows(input int n);
    eol = 1'b1;
    repeat (n) tick();
    eol = 1'b0;
  endtask

  // npix pixels from x=0, black where dlo <= x < dhi, white elsewhere
  task automatic row(input int npix, input int dlo, input int dhi);
    for (int x = 0; x < npix; x++) begin
      pix_valid = 1'b1;
      pix_data  = (x >= dlo && x < dhi) ? 16'h0000 : 16'hFFFF;
      tick();
    end
    pix_valid = 1'b0;
    eol = 1'b1;
    tick();
    eol = 1'b0;
  endtask

  task automatic zone1_body();
    blank_rows(400);
    repeat (40) row(160, 80, 160);
  endtask

  task automatic zone3_frame(input int ndark);
    start_frame();
    blank_rows(400);
    repeat (4) row(320, 240, 280);
    row(320, 240, 240 + ndark - 160);
  endtask

  task automatic empty_frame();
    start_frame();
  endtask

  // Issue eof, wait for the update pulse, check latency and results
  task automatic end_frame(input string tag, input int sof_at,
                           input logic [7:0] ek, input logic [7:0] eo,
                           input logic [15:0] ed);
    int lat;
    logic [7:0]  k;
    logic [7:0]  o;
    logic [15:0] d;
    eof = 1'b1;
    tick();
    eof = 1'b0;
    lat = 1;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    while (!keys_valid && lat < 40) begin
      sof = (lat == sof_at);
      tick();
      lat++;
    end
    sof = 1'b0;
    k = keys;
    o = key_onset;
    d = debug_out;
    chk({tag, ".latency"}, 32'(lat), 32'(KEYS + 1));
    chk({tag, ".keys"}, 32'(k), 32'(ek));
    chk({tag, ".onset"}, 32'(o), 32'(eo));
    chk({tag, ".debug"}, 32'(d), 32'(ed));
    tick();
    chk({tag, ".kv_pulse"}, 32'(keys_valid), 32'd0);
    chk({tag, ".onset_clr"}, 32'(key_onset), 32'd0);
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b0;
    tick();
    tick();
    chk("rst.keys", 32'(keys), 32'd0);
    chk("rst.onset", 32'(key_onset), 32'd0);
    chk("rst.kv", 32'(keys_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.debug", 32'(debug_out), 32'd0);
    rst = 1'b1;
    tick();

    // White frame: nothing is dark
    start_frame();
    blank_rows(400);
    repeat (2) row(640, 0, 0);
    blank_rows(38);
    end_frame("white", 0, 8'h00, 8'h00, 16'h0000);

    // Zone 1 dark (3200 px): pressed on the second frame, onset only once
    start_frame(); zone1_body();
    end_frame("z1.f1", 0, 8'h00, 8'h00, 16'h0200);
    start_frame(); zone1_body();
    end_frame("z1.f2", 0, 8'h02, 8'h02, 16'h0200);
    start_frame(); zone1_body();
    end_frame("z1.f3", 0, 8'h02, 8'h00, 16'h0200);
    empty_frame();
    end_frame("z1.rel1", 0, 8'h02, 8'h00, 16'h0000);
    empty_frame();
    end_frame("z1.rel2", 0, 8'h00, 8'h00, 16'h0000);

    // Zone 3 just under and exactly at the hit threshold
    zone3_frame(199);
    end_frame("z3.199a", 0, 8'h00, 8'h00, 16'h0000);
    zone3_frame(199);
    end_frame("z3.199b", 0, 8'h00, 8'h00, 16'h0000);
    zone3_frame(200);
    end_frame("z3.200a", 0, 8'h00, 8'h00, 16'h0800);
    zone3_frame(200);
    end_frame("z3.200b", 0, 8'h08, 8'h08, 16'h0800);
    empty_frame();
    end_frame("z3.rel1", 0, 8'h08, 8'h00, 16'h0000);
    empty_frame();
    end_frame("z3.rel2", 0, 8'h00, 8'h00, 16'h0000);

    // Dark rows just outside the band on both sides
    for (int f = 0; f < 2; f++) begin
      start_frame();
      blank_rows(399);
      row(640, 0, 640);
      blank_rows(40);
      row(640, 0, 640);
      end_frame("band", 0, 8'h00, 8'h00, 16'h0000);
    end

    // sof during EVAL: current output still produced, next frame starts at OUT exit
    start_frame(); zone1_body();
    end_frame("sofev.f1", 3, 8'h00, 8'h00, 16'h0200);
    zone1_body();
    end_frame("sofev.f2", 0, 8'h02, 8'h02, 16'h0200);

    // sof without eof: no update, counters restart (zone 3 data discarded)
    kv0 = kv_cnt;
    zone3_frame(200);
    start_frame(); zone1_body();
    chk("restart.no_kv", 32'(kv_cnt), 32'(kv0));
    end_frame("restart", 0, 8'h02, 8'h00, 16'h0200);
    empty_frame();
    end_frame("sofev.rel1", 0, 8'h02, 8'h00, 16'h0000);
    empty_frame();
    end_frame("sofev.rel2", 0, 8'h00, 8'h00, 16'h0000);

    // Leftmost zone dark; zone-0 count saturates in the debug byte
    for (int f = 0; f < 2; f++) begin
      start_frame();
      blank_rows(400);
      repeat (40) row(80, 0, 80);
      if (f == 0) end_frame("mir.f1", 0, 8'h00, 8'h00, MIR_DBG);
      else        end_frame("mir.f2", 0, MIR_KEY, MIR_KEY, MIR_DBG);
    end

    // Reset mid-frame clears immediately and the next frame runs cleanly
    start_frame();
    blank_rows(400);
    repeat (3) row(80, 0, 80);
    rst = 1'b0;
    #1;
    chk("midrst.keys", 32'(keys), 32'd0);
    chk("midrst.debug", 32'(debug_out), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    empty_frame();
    end_frame("postrst", 0, 8'h00, 8'h00, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
